// File: rtl/fetch_unit.sv
// Instruction fetch for a bracket-looping byte machine: reads one byte per 3 cycles, tracks
// '[' return addresses on a small stack and skips forward over loop bodies entered with a zero cell.
module fetch_unit #(
    parameter int STACK_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] imem_addr,
    input  logic [7:0] imem_data,
    input  logic       cell_zero,
    output logic [7:0] ix,
    output logic       ix_valid,
    input  logic       ix_ready,
    output logic       halted,
    output logic       error
);

    localparam int SpW  = $clog2(STACK_DEPTH) + 1;
    localparam int IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        StFetch,
        StWait,
        StIssue,
        StSkip,
        StHalt,
        StErr
    } state_e;

    state_e           state_q, state_d;
    logic [9:0]       pc_q, pc_d;
    logic [9:0]       depth_q, depth_d;
    logic [SpW-1:0]   sp_q, sp_d;
    logic [7:0]       ix_q, ix_d;
    logic             skip_rd_q, skip_rd_d;
    logic [9:0]       stack_q [STACK_DEPTH];
    logic [9:0]       stack_d [STACK_DEPTH];

    logic [IdxW-1:0]  top_idx;
    logic [IdxW-1:0]  push_idx;
    logic [9:0]       top;
    logic [9:0]       pc_inc;
    logic             pc_last;
    logic             stack_empty;
    logic             stack_full;

    function automatic logic is_open(input logic [3:0] nib);
        return (nib[3:1] == 3'b011) && !nib[0];
    endfunction

    function automatic logic is_close(input logic [3:0] nib);
        return (nib[3:1] == 3'b011) && nib[0];
    endfunction

    assign top_idx     = IdxW'(sp_q - SpW'(1));
    assign push_idx    = IdxW'(sp_q);
    assign top         = stack_q[top_idx];
    assign pc_inc      = pc_q + 10'd1;
    assign pc_last     = (pc_q == 10'h3FF);
    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SpW'(STACK_DEPTH));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        depth_d   = depth_q;
        sp_d      = sp_q;
        ix_d      = ix_q;
        skip_rd_d = skip_rd_q;
        stack_d   = stack_q;

        unique case (state_q)
            StFetch: state_d = StWait;
            StWait: begin
                ix_d    = imem_data;
                state_d = StIssue;
            end
            StIssue: begin
                if (ix_ready) begin
                    // Any pc+1 from 10'h3FF would wrap, so that path always ends in ERR.
                    if (ix_q == 8'hFF) begin
                        if (pc_last) begin
                            state_d = StErr;
                        end else begin
                            pc_d    = pc_inc;
                            state_d = StHalt;
                        end
                    end else if (is_open(ix_q[3:0])) begin
                        if (pc_last) begin
                            state_d = StErr;
                        end else if (cell_zero) begin
                            depth_d   = 10'd1;
                            pc_d      = pc_inc;
                            skip_rd_d = 1'b0;
                            state_d   = StSkip;
                        end else if (stack_full) begin
                            state_d = StErr;
                        end else begin
                            stack_d[push_idx] = pc_q;
                            sp_d              = sp_q + SpW'(1);
                            pc_d              = pc_inc;
                            state_d           = StFetch;
                        end
                    end else if (is_close(ix_q[3:0])) begin
                        if (stack_empty) begin
                            state_d = StErr;
                        end else if (!cell_zero) begin
                            pc_d    = top + 10'd1;
                            state_d = StFetch;
                        end else if (pc_last) begin
                            state_d = StErr;
                        end else begin
                            sp_d    = sp_q - SpW'(1);
                            pc_d    = pc_inc;
                            state_d = StFetch;
                        end
                    end else begin
                        if (pc_last) begin
                            state_d = StErr;
                        end else begin
                            pc_d    = pc_inc;
                            state_d = StFetch;
                        end
                    end
                end
            end
            StSkip: begin
                // skip_rd_q=0: address issued; skip_rd_q=1: imem_data holds the byte at pc.
                if (!skip_rd_q) begin
                    skip_rd_d = 1'b1;
                end else begin
                    skip_rd_d = 1'b0;
                    if (is_open(imem_data[3:0])) begin
                        depth_d = depth_q + 10'd1;
                    end else if (is_close(imem_data[3:0])) begin
                        depth_d = depth_q - 10'd1;
                    end
                    if (pc_last) begin
                        state_d = StErr;
                    end else begin
                        pc_d = pc_inc;
                        if (is_close(imem_data[3:0]) && (depth_q == 10'd1)) begin
                            state_d = StFetch;
                        end
                    end
                end
            end
            StHalt, StErr: ;
            default: state_d = StErr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            pc_q      <= '0;
            depth_q   <= '0;
            sp_q      <= '0;
            ix_q      <= '0;
            skip_rd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            depth_q   <= depth_d;
            sp_q      <= sp_d;
            ix_q      <= ix_d;
            skip_rd_q <= skip_rd_d;
        end
    end

    // Entry contents need no reset: sp_q alone defines which entries are live.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign imem_addr = pc_q;
    assign ix        = ix_q;
    assign ix_valid  = (state_q == StIssue);
    assign halted    = (state_q == StHalt);
    assign error     = (state_q == StErr);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a synchronous-read memory model feeds programs, and each
// scenario task checks emitted instructions, their cycles, and halt/error timing.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] imem_addr;
    logic [7:0] imem_data = 8'h00;
    logic       cell_zero = 1'b0;
    logic [7:0] ix;
    logic       ix_valid;
    logic       ix_ready = 1'b1;
    logic       halted;
    logic       error;

    always #5 clk = ~clk;

    fetch_unit #(.STACK_DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .cell_zero (cell_zero),
        .ix        (ix),
        .ix_valid  (ix_valid),
        .ix_ready  (ix_ready),
        .halted    (halted),
        .error     (error)
    );

    logic [7:0] mem [1024];
    always @(posedge clk) imem_data <= mem[imem_addr];

    int         n_pass  = 0;
    int         n_total = 0;
    logic       cz_q [$];
    logic [7:0] emit_ix [$];
    int         emit_cyc [$];
    logic [9:0] addr_log [64];
    logic       halt_log [64];
    logic       err_log  [64];

    task automatic clear_mem;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Cycle 0 is the first cycle after reset deasserts; bracket acceptances consume cz_q.
    task automatic run(input int ncyc);
        emit_ix.delete();
        emit_cyc.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            addr_log[c] = imem_addr;
            halt_log[c] = halted;
            err_log[c]  = error;
            if (ix_valid) begin
                emit_ix.push_back(ix);
                emit_cyc.push_back(c);
                if (ix[3:1] == 3'b011) cell_zero = (cz_q.size() > 0) ? cz_q.pop_front() : 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (imem_addr !== 10'd0) $display("FAIL reset_addr got %h want 000", imem_addr); else n_pass++;
        n_total++; if (ix !== 8'h00) $display("FAIL reset_ix got %h want 00", ix); else n_pass++;
        n_total++; if (ix_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ix_valid); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else n_pass++;
        n_total++; if (error !== 1'b0) $display("FAIL reset_error got %b want 0", error); else n_pass++;
    endtask

    task automatic test_basic;
        logic [7:0] exp_ix [3]  = '{8'h02, 8'h04, 8'hFF};
        int         exp_cyc [3] = '{2, 5, 8};
        clear_mem();
        mem[0] = 8'h02; mem[1] = 8'h04; mem[2] = 8'hFF;
        cz_q.delete(); cell_zero = 1'b0; ix_ready = 1'b1;
        do_reset();
        run(14);
        n_total++; if (addr_log[0] !== 10'd0) $display("FAIL basic_first_addr got %h want 000", addr_log[0]); else n_pass++;
        n_total++; if (emit_ix.size() != 3) $display("FAIL basic_count got %0d want 3", emit_ix.size()); else n_pass++;
        for (int i = 0; i < 3 && i < emit_ix.size(); i++) begin
            n_total++; if (emit_ix[i] !== exp_ix[i]) $display("FAIL basic_ix%0d got %h want %h", i, emit_ix[i], exp_ix[i]); else n_pass++;
            n_total++; if (emit_cyc[i] != exp_cyc[i]) $display("FAIL basic_cyc%0d got %0d want %0d", i, emit_cyc[i], exp_cyc[i]); else n_pass++;
        end
        n_total++; if (halt_log[8] !== 1'b0) $display("FAIL basic_halt_early got %b want 0", halt_log[8]); else n_pass++;
        n_total++; if (halt_log[9] !== 1'b1) $display("FAIL basic_halt got %b want 1", halt_log[9]); else n_pass++;
        n_total++; if (halt_log[13] !== 1'b1) $display("FAIL basic_halt_hold got %b want 1", halt_log[13]); else n_pass++;
        n_total++; if (addr_log[13] !== 10'd3) $display("FAIL basic_halt_addr got %h want 003", addr_log[13]); else n_pass++;
        n_total++; if (err_log[13] !== 1'b0) $display("FAIL basic_no_error got %b want 0", err_log[13]); else n_pass++;
    endtask

    task automatic test_stall;
        clear_mem();
        mem[0] = 8'h02; mem[1] = 8'h04; mem[2] = 8'hFF;
        cz_q.delete(); cell_zero = 1'b0; ix_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                n_total++; if (ix_valid !== 1'b1) $display("FAIL stall_valid c%0d got %b want 1", c, ix_valid); else n_pass++;
                n_total++; if (ix !== 8'h02) $display("FAIL stall_ix c%0d got %h want 02", c, ix); else n_pass++;
                n_total++; if (imem_addr !== 10'd0) $display("FAIL stall_pc c%0d got %h want 000", c, imem_addr); else n_pass++;
            end
        end
        ix_ready = 1'b1;
        @(negedge clk);
        n_total++; if (ix_valid !== 1'b0) $display("FAIL stall_drop got %b want 0", ix_valid); else n_pass++;
        n_total++; if (imem_addr !== 10'd1) $display("FAIL stall_advance got %h want 001", imem_addr); else n_pass++;
        repeat (2) @(negedge clk);
        n_total++; if (ix_valid !== 1'b1 || ix !== 8'h04) $display("FAIL stall_next got %b/%h want 1/04", ix_valid, ix); else n_pass++;
    endtask

    task automatic test_skip;
        clear_mem();
        mem[0] = 8'h06; mem[1] = 8'h02; mem[2] = 8'h07; mem[3] = 8'hFF;
        cz_q.delete(); cz_q.push_back(1'b1); cell_zero = 1'b0; ix_ready = 1'b1;
        do_reset();
        run(14);
        n_total++; if (emit_ix.size() != 2) $display("FAIL skip_count got %0d want 2", emit_ix.size()); else n_pass++;
        if (emit_ix.size() == 2) begin
            n_total++; if (emit_ix[1] !== 8'hFF) $display("FAIL skip_next_ix got %h want ff", emit_ix[1]); else n_pass++;
            n_total++; if (emit_cyc[1] != 9) $display("FAIL skip_next_cyc got %0d want 9", emit_cyc[1]); else n_pass++;
        end
        n_total++; if (addr_log[5] !== 10'd2) $display("FAIL skip_scan_addr got %h want 002", addr_log[5]); else n_pass++;
        n_total++; if (halt_log[10] !== 1'b1) $display("FAIL skip_halt got %b want 1", halt_log[10]); else n_pass++;
        n_total++; if (addr_log[10] !== 10'd4) $display("FAIL skip_pc got %h want 004", addr_log[10]); else n_pass++;
    endtask

    task automatic test_loop;
        logic [7:0] exp_ix [6]  = '{8'h06, 8'h02, 8'h07, 8'h02, 8'h07, 8'hFF};
        int         exp_cyc [6] = '{2, 5, 8, 11, 14, 17};
        clear_mem();
        mem[0] = 8'h06; mem[1] = 8'h02; mem[2] = 8'h07; mem[3] = 8'hFF;
        cz_q.delete(); cz_q.push_back(1'b0); cz_q.push_back(1'b0); cz_q.push_back(1'b1);
        cell_zero = 1'b0; ix_ready = 1'b1;
        do_reset();
        run(22);
        n_total++; if (emit_ix.size() != 6) $display("FAIL loop_count got %0d want 6", emit_ix.size()); else n_pass++;
        for (int i = 0; i < 6 && i < emit_ix.size(); i++) begin
            n_total++; if (emit_ix[i] !== exp_ix[i]) $display("FAIL loop_ix%0d got %h want %h", i, emit_ix[i], exp_ix[i]); else n_pass++;
            n_total++; if (emit_cyc[i] != exp_cyc[i]) $display("FAIL loop_cyc%0d got %0d want %0d", i, emit_cyc[i], exp_cyc[i]); else n_pass++;
        end
        n_total++; if (halt_log[18] !== 1'b1) $display("FAIL loop_halt got %b want 1", halt_log[18]); else n_pass++;
        n_total++; if (addr_log[18] !== 10'd4) $display("FAIL loop_pc got %h want 004", addr_log[18]); else n_pass++;
        n_total++; if (err_log[21] !== 1'b0) $display("FAIL loop_no_error got %b want 0", err_log[21]); else n_pass++;
    endtask

    task automatic test_errors;
        clear_mem();
        mem[0] = 8'h07;
        cz_q.delete(); cell_zero = 1'b0; ix_ready = 1'b1;
        do_reset();
        run(6);
        n_total++; if (emit_ix.size() != 1) $display("FAIL under_count got %0d want 1", emit_ix.size()); else n_pass++;
        n_total++; if (err_log[2] !== 1'b0) $display("FAIL under_early got %b want 0", err_log[2]); else n_pass++;
        n_total++; if (err_log[3] !== 1'b1) $display("FAIL under_error got %b want 1", err_log[3]); else n_pass++;
        n_total++; if (err_log[5] !== 1'b1 || halt_log[5] !== 1'b0) $display("FAIL under_hold got %b/%b want 1/0", err_log[5], halt_log[5]); else n_pass++;
        n_total++; if (addr_log[5] !== 10'd0) $display("FAIL under_addr got %h want 000", addr_log[5]); else n_pass++;

        clear_mem();
        for (int i = 0; i < 17; i++) mem[i] = 8'h06;
        cz_q.delete(); cell_zero = 1'b0;
        do_reset();
        run(56);
        n_total++; if (emit_ix.size() != 17) $display("FAIL over_count got %0d want 17", emit_ix.size()); else n_pass++;
        if (emit_cyc.size() == 17) begin
            n_total++; if (emit_cyc[16] != 50) $display("FAIL over_cyc got %0d want 50", emit_cyc[16]); else n_pass++;
        end
        n_total++; if (err_log[50] !== 1'b0) $display("FAIL over_early got %b want 0", err_log[50]); else n_pass++;
        n_total++; if (err_log[51] !== 1'b1) $display("FAIL over_error got %b want 1", err_log[51]); else n_pass++;
        n_total++; if (addr_log[55] !== 10'd16) $display("FAIL over_addr got %h want 010", addr_log[55]); else n_pass++;
    endtask

    task automatic test_rst_mid_skip;
        clear_mem();
        mem[0] = 8'h06; mem[1] = 8'h02; mem[2] = 8'h07; mem[3] = 8'hFF;
        cz_q.delete(); cz_q.push_back(1'b1); cell_zero = 1'b0; ix_ready = 1'b1;
        do_reset();
        run(5);
        n_total++; if (addr_log[4] !== 10'd1 || ix_valid !== 1'b0) $display("FAIL mid_skip got %h/%b want 001/0", addr_log[4], ix_valid); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (imem_addr !== 10'd0) $display("FAIL rst_skip_addr got %h want 000", imem_addr); else n_pass++;
        n_total++; if (ix !== 8'h00) $display("FAIL rst_skip_ix got %h want 00", ix); else n_pass++;
        n_total++; if (ix_valid !== 1'b0 || halted !== 1'b0 || error !== 1'b0) $display("FAIL rst_skip_flags got %b%b%b want 000", ix_valid, halted, error); else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        cz_q.delete(); cz_q.push_back(1'b0); cell_zero = 1'b0;
        run(6);
        n_total++; if (emit_ix.size() != 2) $display("FAIL refetch_count got %0d want 2", emit_ix.size()); else n_pass++;
        if (emit_ix.size() == 2) begin
            n_total++; if (emit_ix[0] !== 8'h06 || emit_cyc[0] != 2) $display("FAIL refetch_first got %h@%0d want 06@2", emit_ix[0], emit_cyc[0]); else n_pass++;
            n_total++; if (emit_ix[1] !== 8'h02 || emit_cyc[1] != 5) $display("FAIL refetch_second got %h@%0d want 02@5", emit_ix[1], emit_cyc[1]); else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_skip();
        test_loop();
        test_errors();
        test_rst_mid_skip();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
